mem_nport_latency: RTL and testbench

MEM_NPORT_LATENCY -- requirements
Module: mem_nport_latency

---
 rtl/mem_nport_latency.sv | 154 +++++++++++++++
 tb/tb_mem_nport_latency.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_nport_latency.sv
// mem_nport_latency
// Multi-port 32-bit word memory with a programmable per-access wait time.
// Every requester port owns a small wait counter. A request becomes eligible
// to complete once it has waited p_latency cycles. With p_shared=0 every
// eligible port completes in the same cycle. With p_shared=1 a round-robin
// arbiter lets one eligible port complete per cycle.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (counters and arbiter only;
//              storage contents survive)
//   mem_val    per-port request valid
//   mem_wait   per-port stall, 1 = not completed this cycle
//   mem_type   per-port access type, 0 = read, 1 = write
//   mem_addr   per-port byte address, packed 32 bits per port
//   mem_wdata  per-port write data, packed 32 bits per port
//   mem_rdata  per-port read data, valid in the completion cycle, else 0
//
// The back-door tasks write()/read() give simulation-only access to storage.
// They do not touch the counters or the arbiter.
module mem_nport_latency #(
    parameter int p_nports  = 2,
    parameter int p_nwords  = 256,
    parameter int p_latency = 0,
    parameter int p_shared  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [p_nports-1:0]      mem_val,
    output logic [p_nports-1:0]      mem_wait,
    input  logic [p_nports-1:0]      mem_type,
    input  logic [p_nports*32-1:0]   mem_addr,
    input  logic [p_nports*32-1:0]   mem_wdata,
    output logic [p_nports*32-1:0]   mem_rdata
);
    localparam int         c_aw  = $clog2(p_nwords);
    localparam int         c_rrw = (p_nports > 1) ? $clog2(p_nports) : 1;
    localparam logic [3:0] c_lat = 4'(p_latency);

    logic [31:0]         mem_r [p_nwords];
    logic [3:0]          cnt_r [p_nports];
    logic [c_rrw-1:0]    rr_r;
    logic [p_nports-1:0] ready_s;
    logic [p_nports-1:0] grant_s;
    logic                gnt_any_s;
    logic [c_rrw-1:0]    gnt_idx_s;
    logic [c_rrw-1:0]    rr_next_s;

    // Word index: the two byte-offset bits and the bits above the array are ignored.
    function automatic logic [c_aw-1:0] word_idx(input logic [31:0] addr);
        return addr[c_aw+1:2];
    endfunction

    // Back-door storage write. It uses a non-blocking update, so it behaves
    // like a write that commits at the end of the current time step.
    task automatic write(input logic [31:0] addr, input logic [31:0] data);
        mem_r[word_idx(addr)] <= data;
    endtask

    // Back-door storage read.
    task automatic read(input logic [31:0] addr, output logic [31:0] data);
        data = mem_r[word_idx(addr)];
    endtask

    // A port is ready once its request has waited the full latency. Nothing is ready during reset.
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < p_nports; i++) begin
            if (mem_val[i] && !rst && (cnt_r[i] == c_lat)) begin
                ready_s[i] = 1'b1;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    // Grant selection: all ready ports, or the first ready port at or after rr.
    always_comb begin
        grant_s   = '0;
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        if (p_shared == 0) begin
            grant_s = ready_s;
        end else begin
            for (int off = 0; off < p_nports; off++) begin
                if (!gnt_any_s && ready_s[(int'(rr_r) + off) % p_nports]) begin
                    gnt_any_s = 1'b1;
                    gnt_idx_s = c_rrw'((int'(rr_r) + off) % p_nports);
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
            grant_s[gnt_idx_s] = gnt_any_s;
        end
    end

    // The pointer moves to the port just after the one granted, wrapping at p_nports.
    always_comb begin
        rr_next_s = c_rrw'((int'(gnt_idx_s) + 1) % p_nports);
    end

    // Stall and read data. Read data is combinational from the address, so a
    // read sees only writes committed at earlier edges.
    always_comb begin
        mem_wait  = '0;
        mem_rdata = '0;
        for (int i = 0; i < p_nports; i++) begin
            mem_wait[i] = mem_val[i] && !rst && !grant_s[i];
            if (grant_s[i] && !mem_type[i]) begin
                mem_rdata[i*32 +: 32] = mem_r[word_idx(mem_addr[i*32 +: 32])];
            end else begin
                mem_rdata[i*32 +: 32] = 32'h0000_0000;
            end
        end
    end

    // Wait counters: clear on reset, idle, abort or completion; count up to p_latency, then hold.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_nports; i++) begin
            if (rst) begin
                cnt_r[i] <= 4'h0;
            end else if (!mem_val[i] || grant_s[i]) begin
                cnt_r[i] <= 4'h0;
            end else if (cnt_r[i] < c_lat) begin
                cnt_r[i] <= cnt_r[i] + 4'h1;
            end else begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    // Round-robin pointer: it advances only when a shared-mode grant happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r <= '0;
        end else if ((p_shared != 0) && gnt_any_s) begin
            rr_r <= rr_next_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Storage commit. Ports are scanned in ascending order, so the highest
    // port index wins a same-word collision. This block is a plain always
    // because the back-door write task also updates mem_r. Reset gates the
    // grants, so no write commits while rst is high.
    always @(posedge clk) begin
        for (int i = 0; i < p_nports; i++) begin
            if (grant_s[i] && mem_type[i]) begin
                mem_r[word_idx(mem_addr[i*32 +: 32])] <= mem_wdata[i*32 +: 32];
            end
        end
    end
endmodule

// File: tb/tb_mem_nport_latency.sv
// Bench for mem_nport_latency. It runs two configurations side by side:
//   u_a: 2 ports, 256 words, latency 3, independent ports
//   u_b: 3 ports, 16 words, latency 0, shared single bank (round robin)
// A behavioural model tracks, for each port, the cycle in which its current
// request started. It also keeps a word array and a round-robin index. Every
// negedge, the model's view of wait/rdata is compared with the DUT outputs.
// Directed scenarios add literal expectations.
module tb_mem_nport_latency;
    localparam int c_np  [2] = '{2, 3};
    localparam int c_nw  [2] = '{256, 16};
    localparam int c_lat [2] = '{3, 0};
    localparam int c_sh  [2] = '{0, 1};

    logic clk;
    logic rst_a;
    logic rst_b;

    logic        val   [2][4];
    logic        typ   [2][4];
    logic [31:0] addr  [2][4];
    logic [31:0] wdata [2][4];

    logic [1:0]  a_val, a_wait, a_type;
    logic [63:0] a_addr, a_wdata, a_rdata;
    logic [2:0]  b_val, b_wait, b_type;
    logic [95:0] b_addr, b_wdata, b_rdata;

    logic        obs_wait  [2][4];
    logic [31:0] obs_rdata [2][4];

    int total = 0;
    int bad   = 0;

    // model state
    logic [31:0] mm [2][256];
    int          start_c  [2][4];
    int          rr_m     [2];
    logic        exp_wait [2][4];
    int          cyc = 0;
    logic        m_rst, m_any, exp_w;
    logic        m_el [4];
    logic        m_gr [4];
    int          m_q, m_gi;
    logic [31:0] exp_r;
    logic [31:0] bd;

    mem_nport_latency #(.p_nports(2), .p_nwords(256), .p_latency(3), .p_shared(0)) u_a (
        .clk(clk), .rst(rst_a), .mem_val(a_val), .mem_wait(a_wait), .mem_type(a_type),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata)
    );

    mem_nport_latency #(.p_nports(3), .p_nwords(16), .p_latency(0), .p_shared(1)) u_b (
        .clk(clk), .rst(rst_b), .mem_val(b_val), .mem_wait(b_wait), .mem_type(b_type),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata)
    );

    for (genvar p = 0; p < 2; p++) begin : g_a
        assign a_val[p]            = val[0][p];
        assign a_type[p]           = typ[0][p];
        assign a_addr[p*32 +: 32]  = addr[0][p];
        assign a_wdata[p*32 +: 32] = wdata[0][p];
    end
    for (genvar p = 0; p < 3; p++) begin : g_b
        assign b_val[p]            = val[1][p];
        assign b_type[p]           = typ[1][p];
        assign b_addr[p*32 +: 32]  = addr[1][p];
        assign b_wdata[p*32 +: 32] = wdata[1][p];
    end

    // Unpack DUT outputs into one indexable view.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) begin
                obs_wait[k][p]  = 1'b0;
                obs_rdata[k][p] = 32'h0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            obs_wait[0][p]  = a_wait[p];
            obs_rdata[0][p] = a_rdata[p*32 +: 32];
        end
        for (int p = 0; p < 3; p++) begin
            obs_wait[1][p]  = b_wait[p];
            obs_rdata[1][p] = b_rdata[p*32 +: 32];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int widx(input int k, input logic [31:0] a);
        return int'(a >> 2) % c_nw[k];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int k, input logic [31:0] a, input logic [31:0] d);
        if (k == 0) u_a.write(a, d);
        else        u_b.write(a, d);
        mm[k][widx(k, a)] = d;
    endtask

    task automatic idle(input int k);
        for (int p = 0; p < 4; p++) val[k][p] = 1'b0;
    endtask

    // Reference model and comparison, once per cycle, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_rst = (k == 0) ? rst_a : rst_b;
            m_any = 1'b0;
            m_gi  = 0;
            for (int p = 0; p < 4; p++) begin
                m_gr[p] = 1'b0;
                m_el[p] = (p < c_np[k]) && val[k][p] && !m_rst
                          && ((cyc - start_c[k][p]) >= c_lat[k]);
            end
            if (c_sh[k] == 0) begin
                for (int p = 0; p < 4; p++) m_gr[p] = m_el[p];
            end else begin
                for (int o = 0; o < c_np[k]; o++) begin
                    m_q = (rr_m[k] + o) % c_np[k];
                    if (!m_any && m_el[m_q]) begin
                        m_gr[m_q] = 1'b1;
                        m_any     = 1'b1;
                        m_gi      = m_q;
                    end
                end
            end
            for (int p = 0; p < c_np[k]; p++) begin
                exp_w = val[k][p] && !m_rst && !m_gr[p];
                exp_r = (m_gr[p] && !typ[k][p]) ? mm[k][widx(k, addr[k][p])] : 32'h0;
                exp_wait[k][p] = exp_w;
                total++;
                if (obs_wait[k][p] !== exp_w) begin
                    bad++;
                    $display("FAIL model_wait inst=%0d port=%0d cyc=%0d: got %b expected %b",
                             k, p, cyc, obs_wait[k][p], exp_w);
                end
                total++;
                if (obs_rdata[k][p] !== exp_r) begin
                    bad++;
                    $display("FAIL model_rdata inst=%0d port=%0d cyc=%0d: got 0x%08h expected 0x%08h",
                             k, p, cyc, obs_rdata[k][p], exp_r);
                end
            end
            if (m_rst) begin
                rr_m[k] = 0;
                for (int p = 0; p < 4; p++) start_c[k][p] = cyc + 1;
            end else begin
                for (int p = 0; p < c_np[k]; p++) begin
                    if (m_gr[p] && typ[k][p]) mm[k][widx(k, addr[k][p])] = wdata[k][p];
                end
                for (int p = 0; p < 4; p++) begin
                    if (!val[k][p] || m_gr[p]) start_c[k][p] = cyc + 1;
                end
                if ((c_sh[k] != 0) && m_any) rr_m[k] = (m_gi + 1) % c_np[k];
            end
        end
        cyc++;
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rr_m[k] = 0;
            for (int p = 0; p < 4; p++) begin
                val[k][p] = 1'b0; typ[k][p] = 1'b0; addr[k][p] = 32'h0; wdata[k][p] = 32'h0;
                start_c[k][p] = 0; exp_wait[k][p] = 1'b0;
            end
        end

        // Preload storage while in reset.
        step();
        for (int w = 0; w < 256; w++) bd_write(0, 32'(w * 4), $urandom);
        for (int w = 0; w < 16; w++)  bd_write(1, 32'(w * 4), $urandom);
        bd_write(1, 32'h100, 32'hdeadbeef);
        val[0][0] = 1'b1; typ[0][0] = 1'b1; addr[0][0] = 32'h4; wdata[0][0] = 32'h1;
        @(negedge clk);
        chk("reset_wait_a", {30'd0, a_wait}, 32'h0);
        chk("reset_rdata_a", a_rdata[31:0], 32'h0);
        step();
        step();
        idle(0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();

        // Zero latency: the read completes in the cycle val rises.
        val[1][0] = 1'b1; typ[1][0] = 1'b0; addr[1][0] = 32'h100;
        @(negedge clk);
        chk("lat0_wait", {31'd0, b_wait[0]}, 32'h0);
        chk("lat0_rdata", b_rdata[31:0], 32'hdeadbeef);
        step();
        idle(1);

        // Latency 3 write followed by read of the same word.
        val[0][1] = 1'b1; typ[0][1] = 1'b1; addr[0][1] = 32'h40; wdata[0][1] = 32'h12345678;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("lat3_wr_wait", {31'd0, a_wait[1]}, (c < 3) ? 32'h1 : 32'h0);
            step();
        end
        typ[0][1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("lat3_rd_wait", {31'd0, a_wait[1]}, (c < 3) ? 32'h1 : 32'h0);
            if (c == 3) chk("lat3_rd_data", a_rdata[63:32], 32'h12345678);
            step();
        end
        idle(0);

        // Same-word double write: the higher port index wins.
        val[0][0] = 1'b1; typ[0][0] = 1'b1; addr[0][0] = 32'h8; wdata[0][0] = 32'h0000aaaa;
        val[0][1] = 1'b1; typ[0][1] = 1'b1; addr[0][1] = 32'h8; wdata[0][1] = 32'h0000bbbb;
        for (int c = 0; c < 4; c++) step();
        val[0][1] = 1'b0; typ[0][0] = 1'b0;
        for (int c = 0; c < 3; c++) step();
        @(negedge clk);
        chk("collide_rdata", a_rdata[31:0], 32'h0000bbbb);
        step();
        idle(0);

        // Address wrap: 0x400 aliases word 0.
        val[0][0] = 1'b1; typ[0][0] = 1'b1; addr[0][0] = 32'h400; wdata[0][0] = 32'h5;
        for (int c = 0; c < 4; c++) step();
        typ[0][0] = 1'b0; addr[0][0] = 32'h0;
        for (int c = 0; c < 3; c++) step();
        @(negedge clk);
        chk("wrap_rdata", a_rdata[31:0], 32'h5);
        step();
        idle(0);

        // Reset during a write aborts it. The held request then restarts the full wait.
        bd_write(0, 32'h20, 32'h11);
        step();
        val[0][0] = 1'b1; typ[0][0] = 1'b1; addr[0][0] = 32'h20; wdata[0][0] = 32'h77;
        step();
        rst_a = 1'b1;
        @(negedge clk);
        chk("rst_mid_wait", {30'd0, a_wait}, 32'h0);
        step();
        rst_a = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                u_a.read(32'h20, bd);
                chk("rst_mid_old", bd, 32'h11);
            end
            chk("rst_mid_rewait", {31'd0, a_wait[0]}, (c < 3) ? 32'h1 : 32'h0);
            step();
        end
        idle(0);
        @(negedge clk);
        u_a.read(32'h20, bd);
        chk("rst_mid_new", bd, 32'h77);
        step();

        // Shared bank: three simultaneous reads complete in port order.
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        for (int p = 0; p < 3; p++) begin
            val[1][p] = 1'b1; typ[1][p] = 1'b0; addr[1][p] = 32'(4 * (p + 1));
        end
        @(negedge clk);
        chk("rr_c0", {29'd0, b_wait}, 32'h6);
        step();
        val[1][0] = 1'b0;
        @(negedge clk);
        chk("rr_c1", {29'd0, b_wait}, 32'h4);
        step();
        val[1][1] = 1'b0;
        @(negedge clk);
        chk("rr_c2", {29'd0, b_wait}, 32'h0);
        step();
        val[1][2] = 1'b0; val[1][0] = 1'b1; val[1][1] = 1'b1;
        @(negedge clk);
        chk("rr_back_to_0", {29'd0, b_wait}, 32'h2);
        step();
        idle(1);

        // Random traffic. Ports hold while waiting and occasionally abort;
        // reset is pulsed now and then.
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < c_np[k]; p++) begin
                    if (val[k][p] && exp_wait[k][p]) begin
                        if ($urandom_range(0, 31) == 0) val[k][p] = 1'b0;
                    end else begin
                        val[k][p]   = ($urandom_range(0, 3) != 0);
                        typ[k][p]   = 1'($urandom_range(0, 1));
                        addr[k][p]  = (32'($urandom_range(0, 7)) << 2) |
                                      (32'($urandom_range(0, 3)) << 10) |
                                      32'($urandom_range(0, 3));
                        wdata[k][p] = $urandom;
                    end
                end
            end
            rst_a = ($urandom_range(0, 199) == 0);
            rst_b = ($urandom_range(0, 199) == 0);
        end
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle(0);
        idle(1);
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
